// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// EDGE_STICKY_EN (when defined) adds per-channel sticky edge flags.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Counter must hold 0..DB_CYCLES-1 and stay meaningful when DB_CYCLES is 1.
  function automatic int cnt_width(input int db_cycles);
    return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
  endfunction

  function automatic logic edge_qualifies(input edge_mode_t m, input logic new_level);
    logic q;
    case (m)
      EDGE_OFF:  q = 1'b0;
      EDGE_RISE: q = new_level;
      EDGE_FALL: q = ~new_level;
      EDGE_BOTH: q = 1'b1;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: input synchroniser, debounce filter and registered edge pulse.
// EDGE_STICKY_EN adds a sticky flag that latches pulses until cleared.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level_in,
  input  edge_mode_t mode,
  output logic       level_out,
  output logic       pulse_out
`ifdef EDGE_STICKY_EN
  ,
  input  logic       sticky_clr,
  output logic       sticky_out
`endif
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   sync_lvl;

  // Shift the raw level through the synchroniser chain.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], level_in};
    sync_lvl = sync_q[SYNC_STAGES-1];
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive mismatches.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync_lvl == level_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_lvl;
      cnt_d   = {CNT_W{1'b0}};
      pulse_d = edge_qualifies(mode, sync_lvl);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;

`ifdef EDGE_STICKY_EN
  logic sticky_q, sticky_d;

  // A pulse registered on this edge beats a simultaneous clear.
  always_comb begin
    if (pulse_d) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_out = sticky_q;
`endif

endmodule

// File: rtl/multi_edge_detect.sv
// N-channel debounced edge detector with per-channel programmable polarity.
// EDGE_STICKY_EN adds sticky_clr/sticky_out per channel.
module multi_edge_detect
  import edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   level_in,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   level_out,
  output logic [N_CH-1:0]   pulse_out,
  output logic              any_pulse
`ifdef EDGE_STICKY_EN
  ,
  input  logic [N_CH-1:0]   sticky_clr,
  output logic [N_CH-1:0]   sticky_out
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .level_in  (level_in[i]),
      .mode      (edge_mode_t'(mode[2*i +: 2])),
      .level_out (level_out[i]),
      .pulse_out (pulse_out[i])
`ifdef EDGE_STICKY_EN
      ,
      .sticky_clr(sticky_clr[i]),
      .sticky_out(sticky_out[i])
`endif
    );
  end

  // Summary of all registered channel pulses.
  always_comb begin
    any_pulse = |pulse_out;
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect (SYNC_STAGES=2, DB_CYCLES=4).
// Build with EDGE_STICKY_EN defined to also exercise the sticky flags.
module tb_multi_edge_detect;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int DB = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   level_in = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0]   level_out, pulse_out;
  logic           any_pulse;
`ifdef EDGE_STICKY_EN
  logic [N-1:0]   sticky_clr = '0;
  logic [N-1:0]   sticky_out;
`endif

  int checks = 0;
  int failures = 0;

  multi_edge_detect #(.N_CH(N), .SYNC_STAGES(S), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .level_in(level_in), .mode(mode),
    .level_out(level_out), .pulse_out(pulse_out), .any_pulse(any_pulse)
`ifdef EDGE_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky_out(sticky_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: delay line of S samples, then a run-length filter.
  logic [S-1:0] m_hist [N];
  int           m_run  [N];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_pulse = '0;
  logic [N-1:0] m_sticky = '0;

  function automatic logic [2*N:0] exp_vec();
    return {m_level, m_pulse, |m_pulse};
  endfunction

  // Advance one clock edge, update the model with the inputs seen at that edge.
  task automatic tick();
    logic cur;
    logic [1:0] md;
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      if (!reset_n) begin
        m_hist[c] = '0; m_run[c] = 0; m_level[c] = 1'b0; m_pulse[c] = 1'b0; m_sticky[c] = 1'b0;
      end else begin
        cur = m_hist[c][S-1];
        m_hist[c] = {m_hist[c][S-2:0], level_in[c]};
        m_pulse[c] = 1'b0;
        md = mode[2*c +: 2];
        if (cur != m_level[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB) begin
            m_level[c] = cur;
            m_run[c] = 0;
            m_pulse[c] = (md == 2'd3) || (md == 2'd1 && cur) || (md == 2'd2 && !cur);
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef EDGE_STICKY_EN
        if (m_pulse[c]) m_sticky[c] = 1'b1;
        else if (sticky_clr[c]) m_sticky[c] = 1'b0;
`endif
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; level_in = '0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < S + 1; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; level_in = 4'hA; mode = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({level_out, pulse_out, any_pulse} !== 9'd0) begin
        failures++;
        $display("FAIL reset_state: got %b expected 0", {level_out, pulse_out, any_pulse});
      end
    end
    do_reset();
  endtask

  task automatic test_rise_latency();
    do_reset();
    mode = 8'b00_00_00_01;
    level_in[0] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (pulse_out[0] !== (e == 6) || any_pulse !== (e == 6) || level_out[0] !== (e >= 6)) begin
        failures++;
        $display("FAIL rise_latency: edge %0d got p=%b a=%b l=%b", e, pulse_out[0], any_pulse, level_out[0]);
      end
      checks++;
      if ({level_out, pulse_out, any_pulse} !== exp_vec()) begin
        failures++;
        $display("FAIL rise_model: got %b expected %b", {level_out, pulse_out, any_pulse}, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    int npulse = 0;
    do_reset();
    mode = 8'b00_00_10_00;
    for (int e = 0; e < 12; e++) begin
      level_in[1] = (e < 3);
      tick();
      checks++;
      if (level_out[1] !== 1'b0 || pulse_out[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch_filter: edge %0d got l=%b p=%b expected 0", e, level_out[1], pulse_out[1]);
      end
    end
    for (int e = 0; e < 24; e++) begin
      level_in[1] = (e < 6);
      tick();
      if (pulse_out[1]) begin
        npulse++;
        checks++;
        if (level_out[1] !== 1'b0) begin
          failures++;
          $display("FAIL fall_only_level: got %b expected 0 at pulse", level_out[1]);
        end
      end
      checks++;
      if ({level_out, pulse_out, any_pulse} !== exp_vec()) begin
        failures++;
        $display("FAIL glitch_model: got %b expected %b", {level_out, pulse_out, any_pulse}, exp_vec());
      end
    end
    checks++;
    if (npulse != 1) begin
      failures++;
      $display("FAIL fall_only_count: got %0d expected 1", npulse);
    end
  endtask

  task automatic test_toggle();
    int np;
    int last;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      mode = (pass == 0) ? 8'b00_11_00_00 : 8'b00_00_00_00;
      np = 0; last = -1;
      for (int t = 0; t < 44; t++) begin
        if (t % 8 == 0 && t < 32) level_in[2] = ~level_in[2];
        tick();
        if (pulse_out[2]) begin
          np++;
          if (last >= 0) begin
            checks++;
            if (t - last != 8) begin
              failures++;
              $display("FAIL toggle_spacing: got %0d expected 8", t - last);
            end
          end
          last = t;
        end
        checks++;
        if ({level_out, pulse_out, any_pulse} !== exp_vec()) begin
          failures++;
          $display("FAIL toggle_model: got %b expected %b", {level_out, pulse_out, any_pulse}, exp_vec());
        end
      end
      checks++;
      if (np != ((pass == 0) ? 4 : 0) || level_out[2] !== level_in[2]) begin
        failures++;
        $display("FAIL toggle_count: mode pass %0d got %0d pulses level %b", pass, np, level_out[2]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int nall = 0;
    int nother = 0;
    do_reset();
    mode = 8'hFF;
    level_in = 4'hF;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (pulse_out == 4'hF) nall++;
      else if (pulse_out != 4'h0) nother++;
    end
    checks++;
    if (nall != 1 || nother != 0) begin
      failures++;
      $display("FAIL simultaneous: got all=%0d partial=%0d expected 1/0", nall, nother);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 8'b00_00_00_01;
    level_in[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 4) mode[1:0] = 2'b10;
      checks++;
      if (pulse_out[0] !== 1'b0) begin
        failures++;
        $display("FAIL mode_switch: edge %0d got pulse 1 expected 0", e);
      end
    end
    checks++;
    if (level_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL mode_switch_level: got %b expected 1", level_out[0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    mode = 8'hFF;
    level_in = 4'hF;
    for (int e = 0; e < 4; e++) tick();
    reset_n = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if ({level_out, pulse_out, any_pulse} !== 9'd0) begin
        failures++;
        $display("FAIL mid_reset_clear: got %b expected 0", {level_out, pulse_out, any_pulse});
      end
    end
    reset_n = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      tick();
      checks++;
      if (pulse_out !== ((r == 6) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL mid_reset_pulse: edge %0d got %h expected %h", r, pulse_out, (r == 6) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(5, 0) == 0) level_in[c] = ~level_in[c];
      if ($urandom_range(19, 0) == 0) mode = 8'($urandom);
      reset_n = ($urandom_range(299, 0) != 0);
`ifdef EDGE_STICKY_EN
      sticky_clr = 4'($urandom) & 4'($urandom);
`endif
      tick();
      checks++;
      if ({level_out, pulse_out, any_pulse} !== exp_vec()) begin
        failures++;
        $display("FAIL random_model: t=%0d got %b expected %b", t, {level_out, pulse_out, any_pulse}, exp_vec());
      end
`ifdef EDGE_STICKY_EN
      checks++;
      if (sticky_out !== m_sticky) begin
        failures++;
        $display("FAIL random_sticky: got %b expected %b", sticky_out, m_sticky);
      end
`endif
    end
    reset_n = 1'b1;
`ifdef EDGE_STICKY_EN
    sticky_clr = '0;
`endif
  endtask

`ifdef EDGE_STICKY_EN
  task automatic test_sticky();
    do_reset();
    sticky_clr = '0;
    mode = 8'b11_00_00_00;
    level_in[3] = 1'b1;
    for (int e = 0; e < 9; e++) tick();
    checks++;
    if (sticky_out[3] !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set: got %b expected 1", sticky_out[3]);
    end
    level_in[3] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) sticky_clr[3] = 1'b1;
    end
    sticky_clr[3] = 1'b0;
    checks++;
    if (pulse_out[3] !== 1'b1 || sticky_out[3] !== 1'b1) begin
      failures++;
      $display("FAIL sticky_set_wins: got p=%b s=%b expected 1/1", pulse_out[3], sticky_out[3]);
    end
    tick(); tick();
    sticky_clr[3] = 1'b1;
    tick();
    sticky_clr[3] = 1'b0;
    checks++;
    if (sticky_out[3] !== 1'b0 || m_sticky[3] !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear: got %b expected 0", sticky_out[3]);
    end
  endtask
`endif

  initial begin
    for (int c = 0; c < N; c++) begin
      m_hist[c] = '0;
      m_run[c] = 0;
    end
    test_reset();
    test_rise_latency();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_mode_switch();
    test_mid_reset();
`ifdef EDGE_STICKY_EN
    test_sticky();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
